// File: rtl/buffer_read_arbiter.sv
// Arbitrates the frame buffer read port between display scan-out and the filter engine,
// tracks reads through the buffer latency and returns pixels. Optional stats: BUFFER_ARB_STATS_EN.
module buffer_read_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 24,
    parameter int MAX_ADDR     = 76799,
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_grant,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              filt_req,
    input  logic [ADDR_W-1:0] filt_addr,
    output logic              filt_grant,
    output logic              filt_valid,
    output logic [DATA_W-1:0] filt_data,
    output logic [ADDR_W-1:0] buf_addr,
    input  logic [DATA_W-1:0] buf_data,
    output logic              err_range,
    output logic [15:0]       stat_disp_cnt,
    output logic [15:0]       stat_filt_cnt,
    output logic [15:0]       stat_force_cnt
);
    typedef enum logic { ARB_NORMAL, ARB_FORCE } arb_state_e;

    typedef struct packed {
        logic vld;
        logic owner;   // 1 = filter
        logic rerr;
    } tag_t;

    localparam logic [ADDR_W-1:0] MAX_A     = ADDR_W'(MAX_ADDR);
    localparam logic [7:0]        STARVE_TH = 8'(STARVE_LIMIT - 1);

    arb_state_e        state_q, state_d;
    logic [7:0]        starve_q, starve_d;
    logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
    logic              err_range_q, err_range_d;
    logic              disp_valid_q, disp_valid_d, filt_valid_q, filt_valid_d;
    logic [DATA_W-1:0] disp_data_q, disp_data_d, filt_data_q, filt_data_d;
    tag_t              tag_q [READ_LATENCY+1];
    tag_t              tag_d [READ_LATENCY+1];
    tag_t              cap;
    logic              grant;
    logic              rerr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] ret_data;

    always_comb begin
        disp_grant = 1'b0;
        filt_grant = 1'b0;
        if (!reset) begin
            if (state_q == ARB_FORCE) begin
                filt_grant = filt_req;
            end else begin
                disp_grant = disp_req;
                filt_grant = filt_req & ~disp_req;
            end
        end
    end

    assign grant    = disp_grant | filt_grant;
    assign sel_addr = disp_grant ? disp_addr : filt_addr;
    assign rerr     = sel_addr > MAX_A;

    // The force state lasts exactly one cycle; a dropped filter request just wastes it.
    always_comb begin
        starve_d = (filt_req && !filt_grant) ? starve_q + 8'd1 : 8'd0;
        state_d  = ARB_NORMAL;
        if (state_q == ARB_NORMAL && filt_req && !filt_grant && starve_q == STARVE_TH)
            state_d = ARB_FORCE;
    end

    always_comb begin
        buf_addr_d  = grant ? (rerr ? '0 : sel_addr) : buf_addr_q;
        err_range_d = grant & rerr;
        tag_d[0]    = '{vld: grant, owner: filt_grant, rerr: grant & rerr};
        for (int i = 1; i <= READ_LATENCY; i++) tag_d[i] = tag_q[i-1];
    end

    // The last tag stage lines up with the cycle buf_data carries that read.
    assign cap      = tag_q[READ_LATENCY];
    assign ret_data = cap.rerr ? '0 : buf_data;

    always_comb begin
        disp_valid_d = cap.vld & ~cap.owner;
        filt_valid_d = cap.vld &  cap.owner;
        disp_data_d  = disp_valid_d ? ret_data : disp_data_q;
        filt_data_d  = filt_valid_d ? ret_data : filt_data_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARB_NORMAL;
            starve_q     <= '0;
            buf_addr_q   <= '0;
            err_range_q  <= 1'b0;
            disp_valid_q <= 1'b0;
            filt_valid_q <= 1'b0;
            disp_data_q  <= '0;
            filt_data_q  <= '0;
            for (int i = 0; i <= READ_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            buf_addr_q   <= buf_addr_d;
            err_range_q  <= err_range_d;
            disp_valid_q <= disp_valid_d;
            filt_valid_q <= filt_valid_d;
            disp_data_q  <= disp_data_d;
            filt_data_q  <= filt_data_d;
            for (int i = 0; i <= READ_LATENCY; i++) tag_q[i] <= tag_d[i];
        end
    end

    assign buf_addr   = buf_addr_q;
    assign err_range  = err_range_q;
    assign disp_valid = disp_valid_q;
    assign filt_valid = filt_valid_q;
    assign disp_data  = disp_data_q;
    assign filt_data  = filt_data_q;

`ifdef BUFFER_ARB_STATS_EN
    logic [15:0] stat_disp_q, stat_disp_d, stat_filt_q, stat_filt_d, stat_force_q, stat_force_d;
    logic        force_grant;

    assign force_grant = filt_grant & (state_q == ARB_FORCE);

    always_comb begin
        stat_disp_d  = stat_disp_q  + 16'(disp_grant  && stat_disp_q  != 16'hFFFF);
        stat_filt_d  = stat_filt_q  + 16'(filt_grant  && stat_filt_q  != 16'hFFFF);
        stat_force_d = stat_force_q + 16'(force_grant && stat_force_q != 16'hFFFF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_disp_q  <= '0;
            stat_filt_q  <= '0;
            stat_force_q <= '0;
        end else begin
            stat_disp_q  <= stat_disp_d;
            stat_filt_q  <= stat_filt_d;
            stat_force_q <= stat_force_d;
        end
    end

    assign stat_disp_cnt  = stat_disp_q;
    assign stat_filt_cnt  = stat_filt_q;
    assign stat_force_cnt = stat_force_q;
`else
    assign stat_disp_cnt  = 16'd0;
    assign stat_filt_cnt  = 16'd0;
    assign stat_force_cnt = 16'd0;
`endif

endmodule
